// File: rtl/video_pkg.sv
// video_pkg: shared constants and types for the palette output stage.
package video_pkg;
    localparam int CRAM_AW = 8;
    localparam int RGB_W   = 5;
    localparam int RGB15_W = 3 * RGB_W;
    localparam int R_LSB   = 10;
    localparam int G_LSB   = 5;
    localparam int B_LSB   = 0;
    localparam logic [1:0] R_ZX = 2'd0;
    localparam logic [1:0] R_HC = 2'd1;
    localparam logic [1:0] R_XC = 2'd2;
    localparam logic [1:0] R_TX = 2'd3;
    typedef enum logic {W_IDLE, W_LO_HELD} wr_state_t;
endpackage

// File: rtl/video_cram.sv
// video_cram: simple dual-port colour RAM with one write port and a read-first
// synchronous read port.
module video_cram import video_pkg::*; #(
    parameter int AW = CRAM_AW,
    parameter int DW = RGB15_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/video_palette_out.sv
// video_palette_out: looks plex indexes up in the colour RAM and drives registered
// RGB15; also owns the CPU byte-wide CRAM write path.
module video_palette_out #(
    parameter int CRAM_AW = video_pkg::CRAM_AW,
    parameter int RGB_W   = video_pkg::RGB_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c1,
    input  logic               c3,
    input  logic [7:0]         vplex_in,
    input  logic               hires,
    input  logic [3:0]         hpal,
    input  logic               blank,
    input  logic [CRAM_AW-1:0] wr_addr,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic [7:0]         wr_data,
    input  logic               wr_autoinc,
    output logic [RGB_W-1:0]   vred,
    output logic [RGB_W-1:0]   vgrn,
    output logic [RGB_W-1:0]   vblu,
    output logic               cram_busy
);
    import video_pkg::*;
    localparam int CW = 3 * RGB_W;
    wr_state_t state, state_n;
    logic [7:0] lo, lo_n;
    logic [CRAM_AW-1:0] ptr, ptr_n, idx_a, idx_b;
    logic blank_r, hires_r, rd_a, rd_b, ld_a, ld_b, we, unused_ok;
    logic [CW-1:0] rgb, rd_data;
    assign unused_ok = wr_data[7];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= W_IDLE;
            lo    <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            lo    <= lo_n;
            ptr   <= ptr_n;
        end
    end
    // wr_hi takes priority over a same-clock wr_lo and commits with the old latch
    always_comb begin
        state_n = state;
        lo_n    = lo;
        ptr_n   = ptr;
        we      = 1'b0;
        if (wr_hi) begin
            we      = (state == W_LO_HELD) || wr_autoinc;
            ptr_n   = (we && wr_autoinc) ? ptr + 1'b1 : ptr;
            state_n = W_IDLE;
        end else if (wr_lo) begin
            lo_n    = wr_data;
            ptr_n   = wr_addr;
            state_n = W_LO_HELD;
        end
    end
    assign cram_busy = (state == W_LO_HELD);
    video_cram #(.AW(CRAM_AW), .DW(CW)) u_cram (
        .clk   (clk),
        .we    (we && rst_n),
        .waddr (ptr),
        .wdata ({wr_data[6:0], lo}),
        .raddr (rd_b ? idx_b : idx_a),
        .rdata (rd_data)
    );
    // rd_a/rd_b mark the read cycle of each half; ld_a/ld_b load RGB one clock later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_a   <= '0;
            idx_b   <= '0;
            blank_r <= 1'b0;
            hires_r <= 1'b0;
            rd_a    <= 1'b0;
            rd_b    <= 1'b0;
            ld_a    <= 1'b0;
            ld_b    <= 1'b0;
            rgb     <= '0;
        end else begin
            if (c1) begin
                idx_a   <= hires ? {hpal, vplex_in[7:4]} : vplex_in;
                idx_b   <= {hpal, vplex_in[3:0]};
                blank_r <= blank;
                hires_r <= hires;
            end
            rd_a <= c1;
            rd_b <= c3 && hires_r;
            ld_a <= rd_a;
            ld_b <= rd_b;
            if (ld_a || ld_b) rgb <= blank_r ? '0 : rd_data;
        end
    end
    assign vred = rgb[R_LSB +: RGB_W];
    assign vgrn = rgb[G_LSB +: RGB_W];
    assign vblu = rgb[B_LSB +: RGB_W];
endmodule
